// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store.
// Also produces the pipeline stall vector and drops fetches made stale by a taken branch.
module mem_arb_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  input  logic              id_stall_req_i,
  output logic [5:0]        stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {StIdle, StIfBusy, StMemBusy} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_mem_q, last_mem_d;
  logic                drop_q, drop_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [3:0]          bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic                bus_err_q, bus_err_d;
  logic                if_want, mem_want, grant_if, grant_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_mem_q  <= 1'b1;
      drop_q      <= 1'b0;
      wait_cnt_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      drop_q      <= drop_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A request still high in its own done cycle is the one that just completed.
  always_comb begin
    if_want   = if_req_i && !if_flush_i && !if_done_q;
    mem_want  = mem_req_i && !mem_done_q;
    grant_if  = if_want && (!mem_want || last_mem_q);
    grant_mem = mem_want && !grant_if;

    state_d     = state_q;
    last_mem_d  = last_mem_q;
    drop_d      = drop_q;
    wait_cnt_d  = wait_cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          state_d     = StIfBusy;
          last_mem_d  = 1'b0;
          drop_d      = 1'b0;
          wait_cnt_d  = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end else if (grant_mem) begin
          state_d     = StMemBusy;
          last_mem_d  = 1'b1;
          wait_cnt_d  = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end
      end
      StIfBusy: begin
        if (bus_ack_i) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!(drop_q || if_flush_i)) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus_rdata_i;
          end
        end else begin
          drop_d = drop_q || if_flush_i;
        end
      end
      StMemBusy: begin
        if (bus_ack_i) begin
          state_d     = StIdle;
          bus_req_d   = 1'b0;
          mem_done_d  = 1'b1;
          mem_rdata_d = bus_rdata_i;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !bus_ack_i) begin
      if (wait_cnt_q != 8'hFF) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      if (wait_cnt_d == TimeoutCnt) begin
        bus_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    if (mem_req_i && !mem_done_q) begin
      stall_o = 6'b011111;
    end else if (id_stall_req_i) begin
      stall_o = 6'b000111;
    end else if (if_req_i && !if_done_q && !if_flush_i) begin
      stall_o = 6'b000011;
    end else begin
      stall_o = 6'b000000;
    end
    if_rdata_o  = if_rdata_q;
    if_done_o   = if_done_q;
    mem_rdata_o = mem_rdata_q;
    mem_done_o  = mem_done_q;
    bus_req_o   = bus_req_q;
    bus_we_o    = bus_we_q;
    bus_sel_o   = bus_sel_q;
    bus_addr_o  = bus_addr_q;
    bus_wdata_o = bus_wdata_q;
    bus_err_o   = bus_err_q;
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: stall table, directed corner sequences, then random traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_arb_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done, mem_req, mem_we, mem_done, id_stall;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel, bus_sel;
  logic [5:0]  stall;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  mem_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .id_stall_req_i(id_stall), .stall_o(stall),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       mem_req;
    logic       id_stall;
    logic       if_req;
    logic       if_flush;
    logic [5:0] stall;
  } vec_t;
  vec_t vecs[9];

  // Transaction-level model state
  typedef struct {
    bit          valid;
    bit          fetch;
    bit          stale;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;
  txn_t        cur;
  bit          last_was_mem;
  bit          e_if_done, e_mem_done;
  logic [31:0] e_if_rdata, e_mem_rdata;
  bit          if_fin, mem_fin;

  function automatic logic [5:0] exp_stall();
    if (mem_req && !e_mem_done) return 6'b011111;
    if (id_stall) return 6'b000111;
    if (if_req && !e_if_done && !if_flush) return 6'b000011;
    return 6'b000000;
  endfunction

  // Advance the model over one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    bit old_if, old_mem, w_if, w_mem, pick_if;
    old_if     = e_if_done;
    old_mem    = e_mem_done;
    e_if_done  = 0;
    e_mem_done = 0;
    if (cur.valid) begin
      if (cur.fetch && if_flush) cur.stale = 1;
      if (bus_ack) begin
        if (!cur.fetch) begin
          e_mem_done  = 1;
          e_mem_rdata = bus_rdata;
        end else if (!cur.stale) begin
          e_if_done  = 1;
          e_if_rdata = bus_rdata;
        end
        cur.valid = 0;
      end
    end else begin
      w_if    = if_req && !if_flush && !old_if;
      w_mem   = mem_req && !old_mem;
      pick_if = w_if && (!w_mem || last_was_mem);
      if (pick_if) begin
        cur = '{valid: 1, fetch: 1, stale: 0, addr: if_addr, we: 0, sel: 4'hF, wdata: 0};
        last_was_mem = 0;
      end else if (w_mem) begin
        cur = '{valid: 1, fetch: 0, stale: 0, addr: mem_addr, we: mem_we, sel: mem_sel,
                wdata: mem_wdata};
        last_was_mem = 1;
      end
    end
  endtask

  task automatic drive_random();
    bus_ack   = cur.valid && !bus_ack && ($urandom_range(0, 2) == 0);
    bus_rdata = $urandom;
    id_stall  = ($urandom_range(0, 3) == 0);
    if (if_flush) begin
      if_flush = 0;
      if_req   = $urandom_range(0, 1) == 1;
      if_addr  = $urandom;
    end else if (if_fin) begin
      if_fin  = 0;
      if_req  = $urandom_range(0, 1) == 1;
      if_addr = $urandom;
    end else if (e_if_done) begin
      if_fin = 1;
    end else if (!if_req) begin
      if_req  = $urandom_range(0, 2) == 0;
      if_addr = $urandom;
    end else if ($urandom_range(0, 7) == 0) begin
      if_flush = 1;
    end
    if (mem_fin || (!mem_req && !e_mem_done)) begin
      mem_fin   = 0;
      mem_req   = $urandom_range(0, 2) == 0;
      mem_we    = $urandom_range(0, 1) == 1;
      mem_sel   = 4'($urandom_range(1, 15));
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end else if (e_mem_done) begin
      mem_fin = 1;
    end
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = 0; if_flush = 0; mem_req = 0; mem_we = 0; mem_sel = 0;
    mem_addr = 0; mem_wdata = 0; id_stall = 0; bus_ack = 0; bus_rdata = 0;
    vecs[0] = '{0, 0, 0, 0, 6'b000000};
    vecs[1] = '{1, 1, 1, 0, 6'b011111};
    vecs[2] = '{1, 0, 0, 0, 6'b011111};
    vecs[3] = '{0, 1, 1, 0, 6'b000111};
    vecs[4] = '{0, 1, 0, 1, 6'b000111};
    vecs[5] = '{0, 0, 1, 0, 6'b000011};
    vecs[6] = '{0, 0, 1, 1, 6'b000000};
    vecs[7] = '{0, 0, 0, 1, 6'b000000};
    vecs[8] = '{1, 0, 1, 1, 6'b011111};
    tick();
    chk("rst bus_req", bus_req, 0);
    chk("rst if_done", if_done, 0);
    chk("rst mem_done", mem_done, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst bus_addr", bus_addr, 0);
    // Held in reset so done flags stay low and stall is purely the input priority.
    for (int i = 0; i < 9; i++) begin
      mem_req = vecs[i].mem_req; id_stall = vecs[i].id_stall;
      if_req = vecs[i].if_req; if_flush = vecs[i].if_flush;
      #1;
      chk($sformatf("table stall[%0d]", i), stall, vecs[i].stall);
      tick();
    end
    mem_req = 0; id_stall = 0; if_req = 0; if_flush = 0; rst = 0;
    tick();

    // Minimum-latency fetch
    if_req = 1; if_addr = 32'h100; #1;
    chk("t1 stall N", stall, 6'b000011);
    tick();
    chk("t1 bus_req", bus_req, 1);
    chk("t1 bus_addr", bus_addr, 32'h100);
    chk("t1 stall N+1", stall, 6'b000011);
    bus_ack = 1; bus_rdata = 32'h13;
    tick();
    chk("t1 if_done", if_done, 1);
    chk("t1 if_rdata", if_rdata, 32'h13);
    chk("t1 stall N+2", stall, 0);
    chk("t1 bus_req drop", bus_req, 0);
    bus_ack = 0; if_req = 0;
    tick();
    chk("t1 if_done pulse", if_done, 0);

    // Store with byte enables, 3-cycle latency
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3 bus_req", bus_req, 1);
      chk("t3 bus_we", bus_we, 1);
      chk("t3 bus_sel", bus_sel, 4'b0011);
      chk("t3 bus_addr", bus_addr, 32'h2000);
      chk("t3 bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("t3 stall", stall, 6'b011111);
      if (i == 2) begin bus_ack = 1; bus_rdata = 32'hCAFE0000; end
      tick();
    end
    chk("t3 mem_done", mem_done, 1);
    chk("t3 stall done", stall, 0);
    bus_ack = 0; mem_req = 0; mem_we = 0;
    tick();
    chk("t3 mem_done pulse", mem_done, 0);

    // Simultaneous requests after a MEM grant: IF first, then MEM
    if_req = 1; if_addr = 32'h300; mem_req = 1; mem_sel = 4'hF; mem_addr = 32'h400; #1;
    chk("t2 stall", stall, 6'b011111);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2 if bus_addr", bus_addr, 32'h300);
      chk("t2 if bus_we", bus_we, 0);
      chk("t2 stall if", stall, 6'b011111);
      if (i == 2) begin bus_ack = 1; bus_rdata = 32'h11111111; end
      tick();
    end
    chk("t2 if_done", if_done, 1);
    chk("t2 if_rdata", if_rdata, 32'h11111111);
    chk("t2 mem_done early", mem_done, 0);
    chk("t2 stall if_done", stall, 6'b011111);
    bus_ack = 0; if_req = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2 mem bus_req", bus_req, 1);
      chk("t2 mem bus_addr", bus_addr, 32'h400);
      if (i == 2) begin bus_ack = 1; bus_rdata = 32'h22222222; end
      tick();
    end
    chk("t2 mem_done", mem_done, 1);
    chk("t2 mem_rdata", mem_rdata, 32'h22222222);
    chk("t2 if_done", if_done, 0);
    chk("t2 stall mem_done", stall, 0);
    bus_ack = 0; mem_req = 0;
    tick();

    // Flush during a fetch: result dropped, new fetch granted after the ack
    if_req = 1; if_addr = 32'h500;
    tick();
    chk("t4 bus_addr", bus_addr, 32'h500);
    if_flush = 1; #1;
    chk("t4 stall flush", stall, 0);
    tick();
    if_flush = 0; if_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      chk("t4 bus_addr held", bus_addr, 32'h500);
      chk("t4 if_done busy", if_done, 0);
      if (i == 3) begin bus_ack = 1; bus_rdata = 32'h99999999; end
      tick();
    end
    chk("t4 if_done dropped", if_done, 0);
    chk("t4 if_rdata kept", if_rdata, 32'h11111111);
    chk("t4 bus_req idle", bus_req, 0);
    bus_ack = 0;
    tick();
    chk("t4 new bus_req", bus_req, 1);
    chk("t4 new bus_addr", bus_addr, 32'h200);
    bus_ack = 1; bus_rdata = 32'h77;
    tick();
    chk("t4 new if_done", if_done, 1);
    chk("t4 new if_rdata", if_rdata, 32'h77);
    bus_ack = 0; if_req = 0;
    tick();

    // Timeout: bus_err in the 256th busy cycle, sticky, late ack still completes
    mem_req = 1; mem_we = 0; mem_addr = 32'h600;
    tick();
    repeat (254) tick();
    chk("t5 bus_err early", bus_err, 0);
    chk("t5 bus_req", bus_req, 1);
    tick();
    chk("t5 bus_err set", bus_err, 1);
    repeat (5) tick();
    chk("t5 bus_err sticky", bus_err, 1);
    chk("t5 bus_addr", bus_addr, 32'h600);
    bus_ack = 1; bus_rdata = 32'h5555;
    tick();
    chk("t5 mem_done", mem_done, 1);
    chk("t5 mem_rdata", mem_rdata, 32'h5555);
    chk("t5 bus_err after ack", bus_err, 1);
    bus_ack = 0; mem_req = 0;
    tick();

    // Reset in the middle of a MEM access
    mem_req = 1; mem_addr = 32'h700;
    tick();
    chk("t6 bus_req", bus_req, 1);
    tick();
    rst = 1; mem_req = 0;
    tick();
    chk("t6 bus_req rst", bus_req, 0);
    chk("t6 stall rst", stall, 0);
    chk("t6 bus_err rst", bus_err, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6 no mem_done", mem_done, 0);
      chk("t6 bus_req idle", bus_req, 0);
    end

    // Random traffic against the model
    rst = 1;
    tick();
    rst = 0;
    cur = '{valid: 0, fetch: 0, stale: 0, addr: 0, we: 0, sel: 0, wdata: 0};
    last_was_mem = 1; e_if_done = 0; e_mem_done = 0; e_if_rdata = 0; e_mem_rdata = 0;
    if_fin = 0; mem_fin = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_random();
      #1;
      chk("rnd stall", stall, exp_stall());
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd bus_req", bus_req, cur.valid);
      if (cur.valid) begin
        chk("rnd bus_addr", bus_addr, cur.addr);
        chk("rnd bus_we", bus_we, cur.we);
        if (!cur.fetch) chk("rnd bus_sel", bus_sel, cur.sel);
        if (cur.we) chk("rnd bus_wdata", bus_wdata, cur.wdata);
      end
      chk("rnd if_done", if_done, e_if_done);
      chk("rnd mem_done", mem_done, e_mem_done);
      chk("rnd if_rdata", if_rdata, e_if_rdata);
      chk("rnd mem_rdata", mem_rdata, e_mem_rdata);
      chk("rnd bus_err", bus_err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
